// File: rtl/str_vga_gen_param.sv
// Parametrised stream-VGA timing generator. Owns the H/V counters, decodes sync and
// active-video from them, and emits one registered strVGA word per enabled pixel clock,
// together with line/frame start strobes and a completed-frame counter.
module str_vga_gen_param #(
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned H_FP     = 16,
  parameter int unsigned H_SYNC   = 96,
  parameter int unsigned H_BP     = 48,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned V_FP     = 10,
  parameter int unsigned V_SYNC   = 2,
  parameter int unsigned V_BP     = 33,
  parameter bit          H_POL    = 1'b0,
  parameter bit          V_POL    = 1'b0,
  parameter int unsigned XW       = 10,
  parameter int unsigned YW       = 10,
  parameter int unsigned FW       = 8
) (
  input  logic                px_clk,
  input  logic                reset,
  input  logic                px_en,
  output logic [XW+YW+2:0]    strVGA,
  output logic                line_start,
  output logic                frame_start,
  output logic [FW-1:0]       frame_cnt
);

  localparam int unsigned HTotal   = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned VTotal   = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned HSyncBeg = H_ACTIVE + H_FP;
  localparam int unsigned HSyncEnd = H_ACTIVE + H_FP + H_SYNC;
  localparam int unsigned VSyncBeg = V_ACTIVE + V_FP;
  localparam int unsigned VSyncEnd = V_ACTIVE + V_FP + V_SYNC;
  localparam int unsigned WordW    = XW + YW + 3;

  localparam logic [XW-1:0] HLast = XW'(HTotal - 1);
  localparam logic [YW-1:0] VLast = YW'(VTotal - 1);

  // Word seen during and straight after reset: origin coordinates, blanked, syncs idle.
  localparam logic [WordW-1:0] WordRst = {1'b0, ~V_POL, ~H_POL, {YW{1'b0}}, {XW{1'b0}}};

  logic [XW-1:0]    hc_q, hc_d;
  logic [YW-1:0]    vc_q, vc_d;
  logic [FW-1:0]    fcnt_q, fcnt_d;
  logic [WordW-1:0] word_q, word_d;
  logic             line_q, line_d;
  logic             frame_q, frame_d;

  logic h_last, v_last;
  logic act, hs, vs;

  // Decode of the current (pre-increment) counter state.
  always_comb begin
    h_last = (hc_q == HLast);
    v_last = (vc_q == VLast);
    act    = (32'(hc_q) < H_ACTIVE) && (32'(vc_q) < V_ACTIVE);
    hs     = ((32'(hc_q) >= HSyncBeg) && (32'(hc_q) < HSyncEnd)) ? H_POL : ~H_POL;
    vs     = ((32'(vc_q) >= VSyncBeg) && (32'(vc_q) < VSyncEnd)) ? V_POL : ~V_POL;
  end

  // Next state: everything holds unless px_en; strobes self-clear so they never repeat.
  always_comb begin
    hc_d    = hc_q;
    vc_d    = vc_q;
    fcnt_d  = fcnt_q;
    word_d  = word_q;
    line_d  = 1'b0;
    frame_d = 1'b0;
    if (px_en) begin
      if (h_last) begin
        hc_d = '0;
        if (v_last) begin
          vc_d   = '0;
          fcnt_d = fcnt_q + 1'b1;
        end else begin
          vc_d = vc_q + 1'b1;
        end
      end else begin
        hc_d = hc_q + 1'b1;
      end
      word_d  = {act, vs, hs, vc_q, hc_q};
      line_d  = (hc_q == '0);
      frame_d = (hc_q == '0) && (vc_q == '0);
    end
  end

  // State and output registers; reset overrides px_en.
  always_ff @(posedge px_clk) begin
    if (reset) begin
      hc_q    <= '0;
      vc_q    <= '0;
      fcnt_q  <= '0;
      word_q  <= WordRst;
      line_q  <= 1'b0;
      frame_q <= 1'b0;
    end else begin
      hc_q    <= hc_d;
      vc_q    <= vc_d;
      fcnt_q  <= fcnt_d;
      word_q  <= word_d;
      line_q  <= line_d;
      frame_q <= frame_d;
    end
  end

  assign strVGA      = word_q;
  assign line_start  = line_q;
  assign frame_start = frame_q;
  assign frame_cnt   = fcnt_q;

endmodule
